// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width, grant-source codes and arbiter FSM states
package uart_pkg;
   localparam int DATA_W = 8;
   localparam logic SRC_BTN = 1'b0;
   localparam logic SRC_ECHO = 1'b1;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is taken only alongside a pop
module sync_fifo #(
   parameter int W = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic clk,
   input  logic reset,
   input  logic push_i,
   input  logic [W-1:0] din_i,
   input  logic pop_i,
   output logic [W-1:0] dout_o,
   output logic full_o,
   output logic empty_o,
   output logic [CW-1:0] count_o
);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic do_push, do_pop;
   assign full_o = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_pop = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o = mem_q[rd_q];
   assign count_o = cnt_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_q + AW'(do_push);
         rd_q <= rd_q + AW'(do_pop);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between button sends and RX echo
module uart_tx_arbiter #(
   parameter int DATA_W = uart_pkg::DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int START_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_valid,
   input  logic [DATA_W-1:0] btn_data,
   output logic btn_ready,
   input  logic rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   input  logic rx_parity_err,
   input  logic tx_busy,
   output logic tx_start,
   output logic [DATA_W-1:0] tx_byte,
   output logic grant_src,
   output logic [$clog2(FIFO_DEPTH):0] echo_count,
   output logic echo_overflow,
   output logic tx_timeout
);
   import uart_pkg::*;
   localparam int TW = $clog2(START_TIMEOUT + 1);
   state_t state_q, state_d;
   logic [DATA_W-1:0] byte_q, byte_d, btn_dat_q, btn_dat_d, fifo_dout;
   logic src_q, src_d, last_q, last_d, btn_vld_q, btn_vld_d;
   logic ovf_q, ovf_d, tmo_q, tmo_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic push, pop, sel, full, empty;
   assign push = rx_valid && !rx_parity_err;
   sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_echo_fifo (
      .clk(clk),
      .reset(reset),
      .push_i(push),
      .din_i(rx_data),
      .pop_i(pop),
      .dout_o(fifo_dout),
      .full_o(full),
      .empty_o(empty),
      .count_o(echo_count)
   );
   assign btn_ready = !btn_vld_q;
   assign tx_start = state_q == LAUNCH;
   assign tx_byte = byte_q;
   assign grant_src = src_q;
   assign echo_overflow = ovf_q;
   assign tx_timeout = tmo_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         byte_q <= '0;
         src_q <= SRC_BTN;
         last_q <= SRC_ECHO;
         btn_vld_q <= 1'b0;
         btn_dat_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         tmo_q <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q <= byte_d;
         src_q <= src_d;
         last_q <= last_d;
         btn_vld_q <= btn_vld_d;
         btn_dat_q <= btn_dat_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         tmo_q <= tmo_d;
      end
   end
   // On a tie the source that did not win last time is chosen (1 = echo)
   always_comb begin
      state_d = state_q;
      byte_d = byte_q;
      src_d = src_q;
      last_d = last_q;
      cnt_d = cnt_q;
      tmo_d = tmo_q;
      pop = 1'b0;
      btn_vld_d = btn_vld_q || btn_valid;
      btn_dat_d = (btn_valid && !btn_vld_q) ? btn_data : btn_dat_q;
      sel = (btn_vld_q && !empty) ? (last_q == SRC_BTN) : !empty;
      case (state_q)
         IDLE: begin
            if (btn_vld_q || !empty) begin
               byte_d = sel ? fifo_dout : btn_dat_q;
               pop = sel;
               btn_vld_d = btn_vld_d && sel;
               src_d = sel;
               last_d = sel;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            cnt_d = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) state_d = WAIT_DONE;
            else if (cnt_q == TW'(START_TIMEOUT - 1)) begin
               state_d = IDLE;
               tmo_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         end
         WAIT_DONE: state_d = tx_busy ? WAIT_DONE : IDLE;
         default: state_d = IDLE;
      endcase
      ovf_d = ovf_q || (push && full && !pop);
   end
endmodule
